cr_bank_file: RTL and testbench
===============================

CR_BANK_FILE -- requirements
Module: cr_bank_file

Interface
REQ-001 SHALL provide parameter WIDTH, default 64, meaning control register data width in bits.
REQ-002 SHALL provide parameter NREG, default 32, meaning register count; IDW = clog2(NREG) is the ID width.
REQ-003 SHALL provide parameter NSTAGE, default 3, meaning write-port pipeline stages (EX1..EXn).
REQ-004 SHALL use fixed indices SR=0, PC=1, SPC=2, EXSR=3, VBR=4, CAUSE=5; ZZR = NREG-1 is the null ID (reads zero, writes discarded).
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 clock  in  1  rising-edge clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 hold  in  1  pipeline stall; blocks writeback and PC load.
REQ-009 regIdRd  in  IDW  read ID. regValRd  out  WIDTH  read value.
REQ-010 regIdWr  in  NSTAGE*IDW  per-stage destination ID; slice k is stage k, and k=0 is youngest.
REQ-011 regValWr  in  NSTAGE*WIDTH  per-stage destination value. regWrFlush  in  NSTAGE  per-stage flush.
REQ-012 regInPc  in  WIDTH  next PC. trapReq  in  1. trapCause  in  16. rteReq  in  1.
REQ-013 regOutSr, regOutSpc, regOutVbr  out  WIDTH  register contents. trapBusy  out  1. trapDone  out  1. trapTarget  out  WIDTH.

Function
REQ-014 Writeback: at each edge with !hold and !regWrFlush[NSTAGE-1], the register at regIdWr[NSTAGE-1] SHALL take regValWr[NSTAGE-1], unless the ID is ZZR or PC.
REQ-015 PC SHALL load regInPc at each edge with !hold and SHALL be unchanged under hold.
REQ-016 regValRd SHALL be combinational: stored value of regIdRd; zero for ZZR and for IDs not implemented.
REQ-017 Trap FSM states IDLE, SAVE, VECTOR, RESTORE; trapBusy = (state != IDLE).
REQ-018 IDLE: trapReq -> SAVE; else rteReq -> RESTORE; requests sampled only in IDLE, regardless of hold. trapReq wins if both are asserted.
REQ-019 SAVE (1 cycle): SPC<=PC, EXSR<=SR, CAUSE<=zero-extended trapCause latched at acceptance -> VECTOR.
REQ-020 VECTOR (1 cycle): SR[30]<=1, SR[28]<=1, trapTarget<=VBR + (cause[7:0]<<3) modulo 2^WIDTH, trapDone=1 -> IDLE.
REQ-021 RESTORE (1 cycle): SR<=EXSR, trapTarget<=SPC, trapDone=1 -> IDLE.
REQ-022 trapDone SHALL be a single-cycle pulse, asserted only in the cycle leaving VECTOR or RESTORE.
REQ-023 FSM writes SHALL override a same-cycle writeback to the same register; writebacks to other registers proceed normally.
REQ-024 Requests arriving while trapBusy=1 SHALL be ignored; the requester holds until it observes trapDone.

Reset
REQ-025 On reset: SR = only bit 30 set; PC, SPC, EXSR, CAUSE, VBR, trapTarget = 0; state IDLE; trapBusy=0, trapDone=0.
REQ-026 Registers with IDs 6..NREG-2 SHALL reset to 0.
REQ-027 Reset mid-FSM SHALL return to IDLE with no trapDone pulse; reset overrides hold and all writes.

Configuration
REQ-028 Macro CRBANK_FWD_EN: when defined, regValRd SHALL forward from the youngest non-flushed stage k whose regIdWr[k] equals regIdRd (not ZZR/PC); this applies under hold too.
REQ-029 Without CRBANK_FWD_EN, regValRd SHALL return stored values only; there is no bypass logic.

Verification
REQ-030 Reset; read SR -> 0x0000_0000_4000_0000, trapBusy=0; write VBR=0x1000 via last stage -> next-cycle read 0x1000.
REQ-031 hold=1 with last-stage write VBR=0x2000 and regInPc=0x40 -> VBR and PC unchanged; release -> both update next edge.
REQ-032 VBR=0x1000, PC=0x80, trapReq with cause 0x0005 -> SAVE then VECTOR; SPC=0x80, CAUSE=5, SR bits 30/28 set, trapTarget=0x1028, trapDone pulses once.
REQ-033 trapReq and rteReq asserted together in IDLE -> trap path taken; the RTE is ignored until it is re-asserted after trapDone.
REQ-034 RTE with EXSR=0x1234 and SPC=0x200 -> SR=0x1234, trapTarget=0x200 after 1 cycle; reset asserted in SAVE -> IDLE, no trapDone.
REQ-035 With CRBANK_FWD_EN: stage0 writes SR=0xAA and stage2 writes SR=0xBB, both unflushed -> read 0xAA. Flush stage0 -> read 0xBB. Without the macro -> read stored SR.

Source files
------------

// File: rtl/cr_bank_file_if.sv
// Bus bundle for cr_bank_file: read port, staged write ports, PC input, trap/RTE handshake.
// The slave modport faces the register bank, and the master modport faces the pipeline.
interface cr_bank_file_if #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned NREG   = 32,
    parameter int unsigned NSTAGE = 3
);
    localparam int unsigned IDW = $clog2(NREG);

    logic                     hold;
    logic [IDW-1:0]           regIdRd;
    logic [WIDTH-1:0]         regValRd;
    logic [NSTAGE*IDW-1:0]    regIdWr;
    logic [NSTAGE*WIDTH-1:0]  regValWr;
    logic [NSTAGE-1:0]        regWrFlush;
    logic [WIDTH-1:0]         regInPc;
    logic                     trapReq;
    logic [15:0]              trapCause;
    logic                     rteReq;
    logic [WIDTH-1:0]         regOutSr;
    logic [WIDTH-1:0]         regOutSpc;
    logic [WIDTH-1:0]         regOutVbr;
    logic                     trapBusy;
    logic                     trapDone;
    logic [WIDTH-1:0]         trapTarget;

    modport master (
        output hold, regIdRd, regIdWr, regValWr, regWrFlush, regInPc,
               trapReq, trapCause, rteReq,
        input  regValRd, regOutSr, regOutSpc, regOutVbr, trapBusy, trapDone, trapTarget
    );

    modport slave (
        input  hold, regIdRd, regIdWr, regValWr, regWrFlush, regInPc,
               trapReq, trapCause, rteReq,
        output regValRd, regOutSr, regOutSpc, regOutVbr, trapBusy, trapDone, trapTarget
    );
endinterface

// File: rtl/cr_bank_file.sv
// Control register bank with pipelined writeback, PC load and a trap/RTE sequencer.
// Optional macro CRBANK_FWD_EN adds read forwarding from in-flight pipeline stages.
module cr_bank_file #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned NREG   = 32,
    parameter int unsigned NSTAGE = 3
) (
    input logic          clock,
    input logic          reset,
    cr_bank_file_if.slave bus
);
    localparam int unsigned IDW   = $clog2(NREG);
    localparam int unsigned NImpl = NREG - 1;

    localparam int unsigned RSr    = 0;
    localparam int unsigned RPc    = 1;
    localparam int unsigned RSpc   = 2;
    localparam int unsigned RExsr  = 3;
    localparam int unsigned RVbr   = 4;
    localparam int unsigned RCause = 5;

    localparam logic [IDW-1:0] IdPc  = IDW'(RPc);
    localparam logic [IDW-1:0] IdZzr = IDW'(NREG - 1);

    localparam logic [WIDTH-1:0] SrReset    = WIDTH'(64'h0000_0000_4000_0000);
    localparam logic [WIDTH-1:0] SrTrapBits = WIDTH'(64'h0000_0000_5000_0000);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StSave    = 2'd1;
    localparam logic [1:0] StVector  = 2'd2;
    localparam logic [1:0] StRestore = 2'd3;

    logic [WIDTH-1:0] regs_q [NImpl];
    logic [WIDTH-1:0] regs_d [NImpl];
    logic [1:0]       state_q, state_d;
    logic [15:0]      cause_q, cause_d;
    logic [WIDTH-1:0] target_q, target_d;

    logic [IDW-1:0]   wb_id;
    logic [WIDTH-1:0] wb_val;
    logic             wb_en;
    logic [WIDTH-1:0] rd_val;

    assign wb_id  = bus.regIdWr[(NSTAGE-1)*IDW +: IDW];
    assign wb_val = bus.regValWr[(NSTAGE-1)*WIDTH +: WIDTH];
    assign wb_en  = !bus.hold && !bus.regWrFlush[NSTAGE-1] && (wb_id != IdZzr) && (wb_id != IdPc);

    // Writeback and PC load first; sequencer writes come later so they take priority.
    always_comb begin
        regs_d   = regs_q;
        state_d  = state_q;
        cause_d  = cause_q;
        target_d = target_q;

        for (int unsigned i = 0; i < NImpl; i++) begin
            if (wb_en && (wb_id == IDW'(i))) begin
                regs_d[i] = wb_val;
            end
        end
        if (!bus.hold) begin
            regs_d[RPc] = bus.regInPc;
        end

        case (state_q)
            StIdle: begin
                if (bus.trapReq) begin
                    state_d = StSave;
                    cause_d = bus.trapCause;
                end else if (bus.rteReq) begin
                    state_d = StRestore;
                end
            end
            StSave: begin
                regs_d[RSpc]   = regs_q[RPc];
                regs_d[RExsr]  = regs_q[RSr];
                regs_d[RCause] = WIDTH'(cause_q);
                state_d        = StVector;
            end
            StVector: begin
                regs_d[RSr] = regs_q[RSr] | SrTrapBits;
                target_d    = regs_q[RVbr] + (WIDTH'(cause_q[7:0]) << 3);
                state_d     = StIdle;
            end
            StRestore: begin
                regs_d[RSr] = regs_q[RExsr];
                target_d    = regs_q[RSpc];
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NImpl; i++) begin
                regs_q[i] <= (i == RSr) ? SrReset : '0;
            end
            state_q  <= StIdle;
            cause_q  <= '0;
            target_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NImpl; i++) begin
                regs_q[i] <= regs_d[i];
            end
            state_q  <= state_d;
            cause_q  <= cause_d;
            target_q <= target_d;
        end
    end

    always_comb begin
        rd_val = '0;
        for (int unsigned i = 0; i < NImpl; i++) begin
            if (bus.regIdRd == IDW'(i)) begin
                rd_val = regs_q[i];
            end
        end
`ifdef CRBANK_FWD_EN
        // Walk oldest to youngest so the youngest matching live stage wins.
        if ((bus.regIdRd != IdPc) && (32'(bus.regIdRd) < NImpl)) begin
            for (int k = int'(NSTAGE) - 1; k >= 0; k--) begin
                if (!bus.regWrFlush[k] && (bus.regIdWr[k*IDW +: IDW] == bus.regIdRd)) begin
                    rd_val = bus.regValWr[k*WIDTH +: WIDTH];
                end
            end
        end
`endif
    end

    assign bus.regValRd   = rd_val;
    assign bus.regOutSr   = regs_q[RSr];
    assign bus.regOutSpc  = regs_q[RSpc];
    assign bus.regOutVbr  = regs_q[RVbr];
    assign bus.trapBusy   = (state_q != StIdle);
    // A reset arriving mid-sequence must not leak a completion pulse.
    assign bus.trapDone   = ((state_q == StVector) || (state_q == StRestore)) && !reset;
    assign bus.trapTarget = target_q;
endmodule

// File: tb/tb_cr_bank_file.sv
// Scoreboard bench for cr_bank_file: directed scenarios plus random traffic against a
// behavioural register-file model; a negedge monitor pops expectations and compares.
module tb_cr_bank_file;
    localparam int unsigned WIDTH  = 64;
    localparam int unsigned NREG   = 32;
    localparam int unsigned NSTAGE = 3;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    cr_bank_file_if #(.WIDTH(WIDTH), .NREG(NREG), .NSTAGE(NSTAGE)) bus ();

    cr_bank_file #(.WIDTH(WIDTH), .NREG(NREG), .NSTAGE(NSTAGE)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0] rd, sr, spc, vbr, target;
        logic        busy, done;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Drive variables applied each cycle.
    logic         d_reset, d_hold, d_trap, d_rte;
    logic [4:0]   d_id_rd;
    logic [14:0]  d_id_wr;
    logic [191:0] d_val_wr;
    logic [2:0]   d_flush;
    logic [63:0]  d_pc;
    logic [15:0]  d_cause;

    // Reference model: register array, sequencer phase (0 idle, 1 save, 2 vector, 3 restore).
    logic [63:0] m_reg [32];
    int          m_state;
    logic [15:0] m_cause;
    logic [63:0] m_target;
    bit          m_valid = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_read();
        logic [63:0] v;
        v = (d_id_rd == 5'd31) ? 64'd0 : m_reg[d_id_rd];
`ifdef CRBANK_FWD_EN
        if (d_id_rd != 5'd31 && d_id_rd != 5'd1) begin
            for (int k = 0; k < 3; k++) begin
                if (!d_flush[k] && d_id_wr[k*5 +: 5] == d_id_rd) begin
                    v = d_val_wr[k*64 +: 64];
                    break;
                end
            end
        end
`endif
        return v;
    endfunction

    task automatic model_step();
        logic [63:0] nr [32];
        logic [4:0]  wid;
        if (d_reset) begin
            for (int i = 0; i < 32; i++) m_reg[i] = 64'd0;
            m_reg[0] = 64'h4000_0000;
            m_state  = 0;
            m_cause  = 16'd0;
            m_target = 64'd0;
            m_valid  = 1'b1;
            return;
        end
        nr  = m_reg;
        wid = d_id_wr[14:10];
        if (!d_hold && !d_flush[2] && wid != 5'd31 && wid != 5'd1) nr[wid] = d_val_wr[191:128];
        if (!d_hold) nr[1] = d_pc;
        case (m_state)
            0: begin
                if (d_trap) begin
                    m_state = 1;
                    m_cause = d_cause;
                end else if (d_rte) begin
                    m_state = 3;
                end
            end
            1: begin
                nr[2]   = m_reg[1];
                nr[3]   = m_reg[0];
                nr[5]   = {48'd0, m_cause};
                m_state = 2;
            end
            2: begin
                nr[0]    = m_reg[0] | 64'h5000_0000;
                m_target = m_reg[4] + 64'(m_cause[7:0]) * 64'd8;
                m_state  = 0;
            end
            default: begin
                nr[0]    = m_reg[3];
                m_target = m_reg[2];
                m_state  = 0;
            end
        endcase
        m_reg = nr;
    endtask

    task automatic cycle();
        exp_t e;
        @(posedge clock);
        #2;
        reset          = d_reset;
        bus.hold       = d_hold;
        bus.regIdRd    = d_id_rd;
        bus.regIdWr    = d_id_wr;
        bus.regValWr   = d_val_wr;
        bus.regWrFlush = d_flush;
        bus.regInPc    = d_pc;
        bus.trapReq    = d_trap;
        bus.trapCause  = d_cause;
        bus.rteReq     = d_rte;
        if (m_valid) begin
            e.rd     = model_read();
            e.sr     = m_reg[0];
            e.spc    = m_reg[2];
            e.vbr    = m_reg[4];
            e.target = m_target;
            e.busy   = (m_state != 0);
            e.done   = (m_state == 2 || m_state == 3) && !d_reset;
            exp_q.push_back(e);
        end
        model_step();
    endtask

    task automatic quiet();
        d_reset  = 1'b0;
        d_hold   = 1'b1;
        d_trap   = 1'b0;
        d_rte    = 1'b0;
        d_id_wr  = {3{5'd31}};
        d_val_wr = '0;
        d_flush  = 3'b111;
        d_cause  = 16'd0;
    endtask

    task automatic wr_last(input logic [4:0] id, input logic [63:0] val);
        d_id_wr[14:10]    = id;
        d_val_wr[191:128] = val;
        d_flush[2]        = 1'b0;
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("regValRd", bus.regValRd, e.rd);
            chk("regOutSr", bus.regOutSr, e.sr);
            chk("regOutSpc", bus.regOutSpc, e.spc);
            chk("regOutVbr", bus.regOutVbr, e.vbr);
            chk("trapTarget", bus.trapTarget, e.target);
            chk("trapBusy", 64'(bus.trapBusy), 64'(e.busy));
            chk("trapDone", 64'(bus.trapDone), 64'(e.done));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        quiet();
        d_id_rd = 5'd0;
        d_pc    = 64'd0;
        d_reset = 1'b1;
        cycle();
        cycle();
        d_reset = 1'b0;
        cycle();
        @(negedge clock);
        chk("reset_sr_read", bus.regValRd, 64'h0000_0000_4000_0000);
        chk("reset_busy", 64'(bus.trapBusy), 64'd0);

        // Last-stage write of VBR, PC to 0x80.
        d_hold = 1'b0;
        d_pc   = 64'h80;
        wr_last(5'd4, 64'h1000);
        d_id_rd = 5'd4;
        cycle();
        quiet();
        cycle();
        @(negedge clock);
        chk("vbr_writeback", bus.regValRd, 64'h1000);

        // Stall blocks writeback and PC load; release lets both land.
        d_hold = 1'b1;
        wr_last(5'd4, 64'h2000);
        d_pc = 64'h40;
        cycle();
        cycle();
        @(negedge clock);
        chk("hold_vbr", bus.regOutVbr, 64'h1000);
        d_hold = 1'b0;
        cycle();
        quiet();
        d_id_rd = 5'd1;
        cycle();
        @(negedge clock);
        chk("release_vbr", bus.regOutVbr, 64'h2000);
        chk("release_pc", bus.regValRd, 64'h40);

        // Trap with cause 5: VBR=0x1000, PC=0x80.
        d_hold = 1'b0;
        d_pc   = 64'h80;
        wr_last(5'd4, 64'h1000);
        cycle();
        quiet();
        d_trap  = 1'b1;
        d_cause = 16'h0005;
        cycle();
        d_trap = 1'b0;
        cycle();
        cycle();
        cycle();
        @(negedge clock);
        chk("trap_target", bus.trapTarget, 64'h1028);
        chk("trap_spc", bus.regOutSpc, 64'h80);
        chk("trap_sr", bus.regOutSr, 64'h5000_0000);

        // Simultaneous trap and RTE: trap first, RTE held until after completion.
        d_trap  = 1'b1;
        d_rte   = 1'b1;
        d_cause = 16'h0102;
        cycle();
        d_trap = 1'b0;
        repeat (5) cycle();
        d_rte = 1'b0;
        cycle();

        // RTE with EXSR=0x1234, SPC=0x200.
        d_hold = 1'b0;
        wr_last(5'd3, 64'h1234);
        cycle();
        wr_last(5'd2, 64'h200);
        cycle();
        quiet();
        d_rte = 1'b1;
        cycle();
        d_rte = 1'b0;
        cycle();
        cycle();
        @(negedge clock);
        chk("rte_sr", bus.regOutSr, 64'h1234);
        chk("rte_target", bus.trapTarget, 64'h200);

        // Reset while in SAVE.
        d_trap = 1'b1;
        cycle();
        d_trap  = 1'b0;
        d_reset = 1'b1;
        cycle();
        d_reset = 1'b0;
        cycle();
        @(negedge clock);
        chk("reset_in_save_busy", 64'(bus.trapBusy), 64'd0);

        // Stage 0 and stage 2 both target SR; then flush stage 0.
        d_hold   = 1'b1;
        d_id_rd  = 5'd0;
        d_id_wr  = {5'd0, 5'd9, 5'd0};
        d_val_wr = {64'hBB, 64'h99, 64'hAA};
        d_flush  = 3'b000;
        cycle();
        d_flush = 3'b001;
        cycle();

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            d_reset  = ($urandom_range(0, 99) == 0);
            d_hold   = ($urandom_range(0, 3) == 0);
            d_trap   = ($urandom_range(0, 9) == 0);
            d_rte    = ($urandom_range(0, 9) == 0);
            d_cause  = 16'($urandom);
            d_id_rd  = 5'($urandom);
            d_id_wr  = 15'($urandom);
            d_val_wr = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            d_flush  = 3'($urandom);
            d_pc     = {$urandom, $urandom};
            cycle();
        end

        quiet();
        cycle();
        @(negedge clock);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
